// File: rtl/river_crossing_engine.sv
// Missionaries/cannibals puzzle engine: holds the bank state, checks move legality and applies
// moves after CROSS_CYCLES. Optional UNDO_EN macro adds a circular move history with undo crossings.
module river_crossing_engine #(
    parameter int N_M          = 3,
    parameter int N_C          = 3,
    parameter int BOAT_CAP     = 2,
    parameter int CROSS_CYCLES = 1,
    parameter int CNT_W        = 8,
    parameter int HIST_DEPTH   = 16,
    localparam int W  = $clog2(((N_M > N_C) ? N_M : N_C) + 1),
    localparam int HW = $clog2(HIST_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             move_valid,
    output logic             move_ready,
    input  logic [W-1:0]     move_m,
    input  logic [W-1:0]     move_c,
    input  logic             undo_req,
    output logic [W-1:0]     m_left,
    output logic [W-1:0]     c_left,
    output logic [W-1:0]     m_right,
    output logic [W-1:0]     c_right,
    output logic             boat_side,
    output logic             busy,
    output logic             move_done,
    output logic             err_valid,
    output logic [2:0]       err_code,
    output logic [CNT_W-1:0] move_count,
    output logic [HW-1:0]    hist_level,
    output logic             solution_complete
);
    localparam int TW = (CROSS_CYCLES > 1) ? $clog2(CROSS_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, READY, CROSS, DONE} state_t;

    state_t        state;
    logic [TW-1:0] timer;
    logic [W-1:0]  xm, xc;
    logic          x_undo;

    logic [W-1:0]  src_m, src_c;
    logic [W:0]    load;
    logic [W-1:0]  tl_m, tl_c, tr_m, tr_c;
    logic [W-1:0]  nl_m, nl_c, nr_m, nr_c;
    logic [2:0]    chk_code;

    assign busy              = (state == CROSS);
    assign solution_complete = (state == DONE);

`ifdef UNDO_EN
    localparam int PW = (HIST_DEPTH > 1) ? $clog2(HIST_DEPTH) : 1;

    logic [2*W-1:0] hist_mem [HIST_DEPTH];
    logic [PW-1:0]  wr_ptr, rd_ptr;

    assign move_ready = (state == READY) && !undo_req;
    assign rd_ptr     = (wr_ptr == '0) ? PW'(HIST_DEPTH - 1) : wr_ptr - 1'b1;

    always_ff @(posedge clk) begin
        if (!reset && state == CROSS && timer == '0 && !x_undo)
            hist_mem[wr_ptr] <= {xm, xc};
    end
`else
    logic unused_undo;
    assign unused_undo = undo_req;
    assign move_ready  = (state == READY);
    assign hist_level  = '0;
`endif

    assign src_m = boat_side ? m_right : m_left;
    assign src_c = boat_side ? c_right : c_left;
    assign load  = {1'b0, move_m} + {1'b0, move_c};

    // Legality of the requested move; the post-move banks are only meaningful once rules 1-2 pass.
    always_comb begin
        chk_code = 3'd0;
        tl_m = m_left;
        tl_c = c_left;
        tr_m = m_right;
        tr_c = c_right;
        if (load == '0 || int'(load) > BOAT_CAP) begin
            chk_code = 3'd1;
        end else if (src_m < move_m || src_c < move_c) begin
            chk_code = 3'd2;
        end else begin
            if (!boat_side) begin
                tl_m = m_left - move_m;
                tl_c = c_left - move_c;
                tr_m = m_right + move_m;
                tr_c = c_right + move_c;
            end else begin
                tl_m = m_left + move_m;
                tl_c = c_left + move_c;
                tr_m = m_right - move_m;
                tr_c = c_right - move_c;
            end
            if ((tl_m != '0 && tl_m < tl_c) || (tr_m != '0 && tr_m < tr_c))
                chk_code = 3'd3;
        end
    end

    // The boat side is always the source, so an undo is the latched move crossing back.
    always_comb begin
        if (!boat_side) begin
            nl_m = m_left - xm;
            nl_c = c_left - xc;
            nr_m = m_right + xm;
            nr_c = c_right + xc;
        end else begin
            nl_m = m_left + xm;
            nl_c = c_left + xc;
            nr_m = m_right - xm;
            nr_c = c_right - xc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            timer      <= '0;
            xm         <= '0;
            xc         <= '0;
            x_undo     <= 1'b0;
            m_left     <= '0;
            c_left     <= '0;
            m_right    <= '0;
            c_right    <= '0;
            boat_side  <= 1'b0;
            move_done  <= 1'b0;
            err_valid  <= 1'b0;
            err_code   <= '0;
            move_count <= '0;
`ifdef UNDO_EN
            wr_ptr     <= '0;
            hist_level <= '0;
`endif
        end else begin
            move_done <= 1'b0;
            err_valid <= 1'b0;
            if (start && state != CROSS) begin
                m_left     <= W'(N_M);
                c_left     <= W'(N_C);
                m_right    <= '0;
                c_right    <= '0;
                boat_side  <= 1'b0;
                move_count <= '0;
                err_code   <= '0;
`ifdef UNDO_EN
                wr_ptr     <= '0;
                hist_level <= '0;
`endif
                state      <= READY;
            end else begin
                case (state)
                    READY: begin
`ifdef UNDO_EN
                        if (undo_req) begin
                            if (hist_level == '0) begin
                                err_valid <= 1'b1;
                                err_code  <= 3'd4;
                            end else begin
                                {xm, xc} <= hist_mem[rd_ptr];
                                x_undo   <= 1'b1;
                                timer    <= TW'(CROSS_CYCLES - 1);
                                state    <= CROSS;
                            end
                        end else
`endif
                        if (move_valid) begin
                            if (chk_code != 3'd0) begin
                                err_valid <= 1'b1;
                                err_code  <= chk_code;
                            end else begin
                                xm     <= move_m;
                                xc     <= move_c;
                                x_undo <= 1'b0;
                                timer  <= TW'(CROSS_CYCLES - 1);
                                state  <= CROSS;
                            end
                        end
                    end
                    CROSS: begin
                        if (timer != '0) begin
                            timer <= timer - 1'b1;
                        end else begin
                            m_left    <= nl_m;
                            c_left    <= nl_c;
                            m_right   <= nr_m;
                            c_right   <= nr_c;
                            boat_side <= ~boat_side;
                            move_done <= 1'b1;
                            if (x_undo) begin
                                if (move_count != '0)
                                    move_count <= move_count - 1'b1;
                            end else if (move_count != '1) begin
                                move_count <= move_count + 1'b1;
                            end
`ifdef UNDO_EN
                            if (x_undo) begin
                                hist_level <= hist_level - 1'b1;
                                wr_ptr     <= rd_ptr;
                            end else begin
                                wr_ptr <= (wr_ptr == PW'(HIST_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
                                if (hist_level != HW'(HIST_DEPTH))
                                    hist_level <= hist_level + 1'b1;
                            end
`endif
                            state <= (nl_m == '0 && nl_c == '0) ? DONE : READY;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_river_crossing_engine.sv
// Scoreboard bench for river_crossing_engine: a bank-population model predicts each move_done /
// err_valid event (cycle, code, resulting state); a monitor process pops and compares.
module tb_river_crossing_engine;
    localparam int N_M = 3, N_C = 3, CAP = 2, CC = 4, CW = 4, HD = 4;
    localparam int W = 2, HW = 3;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic clk = 1'b0, reset = 1'b1, start = 1'b0, move_valid = 1'b0, undo_req = 1'b0;
    logic [W-1:0] move_m = '0, move_c = '0;
    logic move_ready, boat_side, busy, move_done, err_valid, solution_complete;
    logic [W-1:0] m_left, c_left, m_right, c_right;
    logic [2:0] err_code;
    logic [CW-1:0] move_count;
    logic [HW-1:0] hist_level;

    river_crossing_engine #(
        .N_M(N_M), .N_C(N_C), .BOAT_CAP(CAP), .CROSS_CYCLES(CC), .CNT_W(CW), .HIST_DEPTH(HD)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .move_valid(move_valid), .move_ready(move_ready),
        .move_m(move_m), .move_c(move_c), .undo_req(undo_req),
        .m_left(m_left), .c_left(c_left), .m_right(m_right), .c_right(c_right),
        .boat_side(boat_side), .busy(busy), .move_done(move_done), .err_valid(err_valid),
        .err_code(err_code), .move_count(move_count), .hist_level(hist_level),
        .solution_complete(solution_complete)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: left-bank populations, boat side, counter and a history list.
    int ml = 0, cl = 0, boat = 0, cnt = 0;
    bit solved = 1'b0;
    int hist[$];

    typedef struct {
        bit is_err;
        int code;
        int ml;
        int cl;
        int boat;
        int cnt;
        int hl;
        int cyc;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    int n_checks = 0, n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit unsafe(input int m, input int c);
        return (m > 0) && (m < c);
    endfunction

    function automatic int rule_code(input int m, input int c);
        int sm, sc, lm, lc;
        sm = boat ? N_M - ml : ml;
        sc = boat ? N_C - cl : cl;
        if (m + c == 0 || m + c > CAP) return 1;
        if (m > sm || c > sc) return 2;
        lm = boat ? ml + m : ml - m;
        lc = boat ? cl + c : cl - c;
        if (unsafe(lm, lc) || unsafe(N_M - lm, N_C - lc)) return 3;
        return 0;
    endfunction

    task automatic model_cross(input int m, input int c);
        if (boat != 0) begin ml += m; cl += c; end
        else begin ml -= m; cl -= c; end
        boat = 1 - boat;
        solved = (ml == 0 && cl == 0);
    endtask

    task automatic model_apply(input int m, input int c);
        model_cross(m, c);
        cnt = (cnt < CNT_MAX) ? cnt + 1 : CNT_MAX;
        hist.push_back(m * 8 + c);
        if (hist.size() > HD) void'(hist.pop_front());
    endtask

    task automatic push_exp(input bit is_err, input int code, input int t);
        exp_t e;
        e.is_err = is_err; e.code = code; e.ml = ml; e.cl = cl; e.boat = boat;
        e.cnt = cnt; e.hl = hist.size(); e.cyc = t;
`ifndef UNDO_EN
        e.hl = 0;
`endif
        sb.push_back(e);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (move_done || err_valid) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_event: move_done=%0b err_valid=%0b, expected none (cycle %0d)",
                             move_done, err_valid, cyc);
                end else begin
                    mon_e = sb.pop_front();
                    chk("event_cycle", cyc, mon_e.cyc);
                    chk("err_valid", int'(err_valid), int'(mon_e.is_err));
                    chk("move_done", int'(move_done), int'(!mon_e.is_err));
                    if (mon_e.is_err) chk("err_code", int'(err_code), mon_e.code);
                    else chk("busy_at_done", int'(busy), 0);
                    chk("m_left", int'(m_left), mon_e.ml);
                    chk("c_left", int'(c_left), mon_e.cl);
                    chk("m_right", int'(m_right), N_M - mon_e.ml);
                    chk("c_right", int'(c_right), N_C - mon_e.cl);
                    chk("boat_side", int'(boat_side), mon_e.boat);
                    chk("move_count", int'(move_count), mon_e.cnt);
                    chk("hist_level", int'(hist_level), mon_e.hl);
                end
            end
        end
    end

    task automatic wait_ready();
        int k = 0;
        while (!move_ready && k < 60) begin @(negedge clk); k++; end
        if (!move_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_ready: move_ready=0 after %0d cycles, required 1", k);
        end
    endtask

    task automatic wait_idle();
        int k = 0;
        while (sb.size() != 0 && k < 60) begin @(negedge clk); k++; end
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL event_timeout: %0d expected events outstanding, required 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic do_move(input int m, input int c);
        int code, t;
        wait_ready();
        move_m = W'(m);
        move_c = W'(c);
        move_valid = 1'b1;
        t = cyc + 1;
        code = rule_code(m, c);
        if (code == 0) begin
            model_apply(m, c);
            push_exp(1'b0, 0, t + CC);
        end else begin
            push_exp(1'b1, code, t);
        end
        @(negedge clk);
        move_valid = 1'b0;
    endtask

`ifdef UNDO_EN
    task automatic do_undo();
        int t, h;
        wait_ready();
        undo_req = 1'b1;
        move_m = W'(0);
        move_c = W'(1);
        move_valid = 1'b1;
        t = cyc + 1;
        if (hist.size() == 0) begin
            push_exp(1'b1, 4, t);
        end else begin
            h = hist.pop_back();
            model_cross(h / 8, h % 8);
            cnt = (cnt > 0) ? cnt - 1 : 0;
            push_exp(1'b0, 0, t + CC);
        end
        @(negedge clk);
        undo_req = 1'b0;
        move_valid = 1'b0;
    endtask
`endif

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ml = N_M; cl = N_C; boat = 0; cnt = 0; solved = 1'b0;
        hist.delete();
        chk("start_m_left", int'(m_left), N_M);
        chk("start_c_left", int'(c_left), N_C);
        chk("start_right", int'(m_right) + int'(c_right), 0);
        chk("start_boat", int'(boat_side), 0);
        chk("start_count", int'(move_count), 0);
        chk("start_err_code", int'(err_code), 0);
        chk("start_hist", int'(hist_level), 0);
        chk("start_ready", int'(move_ready), 1);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_banks"}, int'(m_left) + int'(c_left) + int'(m_right) + int'(c_right), 0);
        chk({tag, "_boat"}, int'(boat_side), 0);
        chk({tag, "_count"}, int'(move_count), 0);
        chk({tag, "_hist"}, int'(hist_level), 0);
        chk({tag, "_err_code"}, int'(err_code), 0);
        chk({tag, "_flags"}, int'({busy, move_ready, move_done, err_valid, solution_complete}), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int cm[11] = '{0, 0, 0, 0, 2, 1, 2, 0, 0, 0, 0};
    int cc[11] = '{2, 1, 2, 1, 0, 1, 0, 1, 2, 1, 2};

    initial begin
        repeat (3) @(negedge clk);
        check_reset("por");
        reset = 1'b0;

        // IDLE must ignore move requests
        move_valid = 1'b1; move_m = W'(0); move_c = W'(2);
        repeat (3) @(negedge clk);
        move_valid = 1'b0;
        chk("idle_ignore_ready", int'(move_ready), 0);
        chk("idle_ignore_m_left", int'(m_left), 0);

        // classic solution
        do_start();
        for (int i = 0; i < 11; i++) begin
            do_move(cm[i], cc[i]);
            wait_idle();
        end
        chk("classic_m_right", int'(m_right), 3);
        chk("classic_c_right", int'(c_right), 3);
        chk("classic_boat", int'(boat_side), 1);
        chk("classic_count", int'(move_count), 11);
        chk("classic_complete", int'(solution_complete), 1);
        chk("classic_ready", int'(move_ready), 0);
        move_valid = 1'b1; move_m = W'(1); move_c = W'(0);
`ifdef UNDO_EN
        undo_req = 1'b1;
`endif
        repeat (4) @(negedge clk);
        move_valid = 1'b0;
        undo_req = 1'b0;
        chk("done_hold_complete", int'(solution_complete), 1);
        chk("done_hold_count", int'(move_count), 11);

        // rejected loads and unsafe move
        do_start();
        do_move(0, 0);
        do_move(2, 1);
        do_move(1, 0);
        wait_idle();
        chk("err_banks_left", int'(m_left) * 8 + int'(c_left), 3 * 8 + 3);
        chk("err_count", int'(move_count), 0);

        // source bank short
        do_start();
        do_move(0, 2);
        wait_idle();
        do_move(1, 0);
        wait_idle();
        chk("short_m_left", int'(m_left), 3);
        chk("short_c_left", int'(c_left), 1);

        // crossing latency with move_valid held throughout
        do_start();
        begin
            int t;
            wait_ready();
            move_m = W'(1); move_c = W'(1); move_valid = 1'b1;
            t = cyc + 1;
            model_apply(1, 1);
            push_exp(1'b0, 0, t + CC);
            for (int k = 0; k < CC; k++) begin
                @(negedge clk);
                chk("cross_busy", int'(busy), 1);
                chk("cross_ready", int'(move_ready), 0);
            end
            @(negedge clk);
            chk("cross_busy_end", int'(busy), 0);
            chk("cross_m_left", int'(m_left), 2);
            move_valid = 1'b0;
            wait_idle();
        end

        // reset mid-crossing
        do_start();
        do_move(0, 0);
        wait_idle();
        move_m = W'(1); move_c = W'(1); move_valid = 1'b1;
        @(negedge clk);
        move_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_reset("abort");
        reset = 1'b0;
        repeat (6) @(negedge clk);
        chk("abort_stays_idle", int'(move_ready), 0);

`ifdef UNDO_EN
        do_start();
        do_move(0, 2);
        wait_idle();
        do_move(0, 1);
        wait_idle();
        do_undo();
        wait_idle();
        chk("undo_m_left", int'(m_left), 3);
        chk("undo_c_left", int'(c_left), 1);
        chk("undo_c_right", int'(c_right), 2);
        chk("undo_boat", int'(boat_side), 1);
        chk("undo_count", int'(move_count), 1);
        chk("undo_hist", int'(hist_level), 1);
        do_undo();
        wait_idle();
        do_undo();
        wait_idle();
        chk("undo_empty_hist", int'(hist_level), 0);
        chk("undo_empty_code", int'(err_code), 4);
`endif

        // randomized requests
        do_start();
        for (int i = 0; i < 300; i++) begin
            if (solved || $urandom_range(0, 39) == 0) begin
                do_start();
            end else begin
`ifdef UNDO_EN
                if ($urandom_range(0, 4) == 0) do_undo();
                else
`endif
                do_move(int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
                wait_idle();
            end
        end
        chk("final_complete_flag", int'(solution_complete), int'(solved));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
